issue_serializer: RTL and testbench

Sequences a two-wide decode bundle into the single issue port of the architectural register file, one instruction per cycle and in program order. Because slot 1 issues only after slot 0's rename has been written at a clock edge, a slot-1 source that reads slot 0's destination sees slot 0's ROB tag without any intra-bundle forwarding. The block sits between the decoder/fetch stage and regfile. It returns the operand tags and values for each issued instruction to the reservation-station dispatch logic.

---
 rtl/issue_serializer.sv | 190 +++++++++++++++++++
 tb/tb_issue_serializer.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_serializer.sv
//============================================================================
// issue_serializer: issues a two-wide decode bundle to the regfile one slot
// per cycle, in program order. Define ISSUE_SER_OUT_REG_EN to register out_*.
// Revision: 1.0
//============================================================================
`default_nettype none

`ifndef ROBENTRY
`define ROBENTRY 3:0
`endif
`ifndef NULL
`define NULL 6'b100000
`endif
`ifndef ENTRY_NULL
`define ENTRY_NULL 4'b0000
`endif

module issue_serializer (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             rollback,
  input  logic             disp_stall,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mask,
  input  logic [5:0]       in_rd0,
  input  logic [5:0]       in_rs1_0,
  input  logic [5:0]       in_rs2_0,
  input  logic [5:0]       in_rd1,
  input  logic [5:0]       in_rs1_1,
  input  logic [5:0]       in_rs2_1,
  input  logic [`ROBENTRY] in_rob0,
  input  logic [`ROBENTRY] in_rob1,
  output logic [5:0]       rf_rd,
  output logic [5:0]       rf_rs1,
  output logic [5:0]       rf_rs2,
  output logic [`ROBENTRY] rf_rob_new_entry,
  output logic             rf_issue_sgn,
  input  logic [`ROBENTRY] rf_Qj,
  input  logic [`ROBENTRY] rf_Qk,
  input  logic [31:0]      rf_Vj,
  input  logic [31:0]      rf_Vk,
  output logic             out_valid,
  output logic             out_slot,
  output logic [`ROBENTRY] out_rob,
  output logic [`ROBENTRY] out_Qj,
  output logic [`ROBENTRY] out_Qk,
  output logic [31:0]      out_Vj,
  output logic [31:0]      out_Vk
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE0 = 2'd1,
    ISSUE1 = 2'd2
  } state_t;

  state_t state, state_next, accept_state;

  logic [1:0]       mask_q;
  logic [5:0]       rd_q  [0:1];
  logic [5:0]       rs1_q [0:1];
  logic [5:0]       rs2_q [0:1];
  logic [`ROBENTRY] rob_q [0:1];

  logic issuing;
  logic cur;
  logic fire;
  logic accept;

  assign issuing = (state == ISSUE0) || (state == ISSUE1);
  assign cur     = (state == ISSUE1);
  assign fire    = !rst && issuing && rdy && !rollback && !disp_stall;

  // A new bundle may land only when the current one finishes at this edge.
  assign in_ready = !rst && rdy && !rollback
                  && ((state == IDLE) || (state == ISSUE1) || ((state == ISSUE0) && !mask_q[1]))
                  && !(issuing && disp_stall);
  assign accept   = in_valid && in_ready;

  assign accept_state = in_mask[0] ? ISSUE0 : (in_mask[1] ? ISSUE1 : IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next       = state;
    rf_rd            = `NULL;
    rf_rs1           = `NULL;
    rf_rs2           = `NULL;
    rf_rob_new_entry = `ENTRY_NULL;
    rf_issue_sgn     = fire;

    if (issuing) begin
      rf_rd            = rd_q[cur];
      rf_rs1           = rs1_q[cur];
      rf_rs2           = rs2_q[cur];
      rf_rob_new_entry = rob_q[cur];
    end

    if (rollback) begin
      state_next = IDLE;
    end else if (rdy && !(issuing && disp_stall)) begin
      case (state)
        IDLE:    if (accept) state_next = accept_state;
        ISSUE0: begin
          if (mask_q[1])   state_next = ISSUE1;
          else if (accept) state_next = accept_state;
          else             state_next = IDLE;
        end
        ISSUE1:  state_next = accept ? accept_state : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        rd_q[i]  <= `NULL;
        rs1_q[i] <= `NULL;
        rs2_q[i] <= `NULL;
        rob_q[i] <= `ENTRY_NULL;
      end
    end else if (accept) begin
      mask_q   <= in_mask;
      rd_q[0]  <= in_rd0;
      rs1_q[0] <= in_rs1_0;
      rs2_q[0] <= in_rs2_0;
      rob_q[0] <= in_rob0;
      rd_q[1]  <= in_rd1;
      rs1_q[1] <= in_rs1_1;
      rs2_q[1] <= in_rs2_1;
      rob_q[1] <= in_rob1;
    end
  end

`ifdef ISSUE_SER_OUT_REG_EN
  // fire is already low under !rdy and rollback, so the pulse self-clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_slot  <= 1'b0;
      out_rob   <= `ENTRY_NULL;
      out_Qj    <= `ENTRY_NULL;
      out_Qk    <= `ENTRY_NULL;
      out_Vj    <= 32'd0;
      out_Vk    <= 32'd0;
    end else begin
      out_valid <= fire;
      if (fire) begin
        out_slot <= cur;
        out_rob  <= rob_q[cur];
        out_Qj   <= rf_Qj;
        out_Qk   <= rf_Qk;
        out_Vj   <= rf_Vj;
        out_Vk   <= rf_Vk;
      end
    end
  end
`else
  always_comb begin
    out_valid = fire;
    out_slot  = 1'b0;
    out_rob   = `ENTRY_NULL;
    out_Qj    = `ENTRY_NULL;
    out_Qk    = `ENTRY_NULL;
    out_Vj    = 32'd0;
    out_Vk    = 32'd0;
    if (fire) begin
      out_slot = cur;
      out_rob  = rob_q[cur];
      out_Qj   = rf_Qj;
      out_Qk   = rf_Qk;
      out_Vj   = rf_Vj;
      out_Vk   = rf_Vk;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_issue_serializer.sv
//============================================================================
// tb_issue_serializer: directed and random stimulus for issue_serializer with
// a regfile stand-in and an in-order rename reference model.
// Revision: 1.0
//============================================================================
`default_nettype none

`ifndef ROBENTRY
`define ROBENTRY 3:0
`endif
`ifndef NULL
`define NULL 6'b100000
`endif
`ifndef ENTRY_NULL
`define ENTRY_NULL 4'b0000
`endif

module tb_issue_serializer;

  typedef logic [`ROBENTRY] tag_t;
  localparam logic [5:0] RNULL = `NULL;
  localparam tag_t       ENULL = `ENTRY_NULL;

  typedef struct packed {
    logic       slot;
    tag_t       rob;
    logic [5:0] rd;
    logic [5:0] rs1;
    logic [5:0] rs2;
  } inst_t;

  logic clk = 1'b0;
  logic rst = 1'b1, rdy = 1'b1, rollback = 1'b0, disp_stall = 1'b0, in_valid = 1'b0;
  logic [1:0] in_mask = 2'b00;
  logic [5:0] in_rd0 = RNULL, in_rs1_0 = RNULL, in_rs2_0 = RNULL;
  logic [5:0] in_rd1 = RNULL, in_rs1_1 = RNULL, in_rs2_1 = RNULL;
  tag_t in_rob0 = ENULL, in_rob1 = ENULL;
  logic in_ready;
  logic [5:0] rf_rd, rf_rs1, rf_rs2;
  tag_t rf_rob_new_entry, rf_Qj, rf_Qk;
  logic rf_issue_sgn;
  logic [31:0] rf_Vj, rf_Vk;
  logic out_valid, out_slot;
  tag_t out_rob, out_Qj, out_Qk;
  logic [31:0] out_Vj, out_Vk;

  issue_serializer dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .disp_stall(disp_stall),
    .in_valid(in_valid), .in_ready(in_ready), .in_mask(in_mask),
    .in_rd0(in_rd0), .in_rs1_0(in_rs1_0), .in_rs2_0(in_rs2_0),
    .in_rd1(in_rd1), .in_rs1_1(in_rs1_1), .in_rs2_1(in_rs2_1),
    .in_rob0(in_rob0), .in_rob1(in_rob1),
    .rf_rd(rf_rd), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .rf_rob_new_entry(rf_rob_new_entry), .rf_issue_sgn(rf_issue_sgn),
    .rf_Qj(rf_Qj), .rf_Qk(rf_Qk), .rf_Vj(rf_Vj), .rf_Vk(rf_Vk),
    .out_valid(out_valid), .out_slot(out_slot), .out_rob(out_rob),
    .out_Qj(out_Qj), .out_Qk(out_Qk), .out_Vj(out_Vj), .out_Vk(out_Vk)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] arch_val(input logic [5:0] r);
    return {16'hA500, 2'b00, r, 2'b00, r};
  endfunction

  // Regfile stand-in: renames at the issue edge, flushes tags on rollback.
  tag_t rf_tag [0:63];
  always @(posedge clk) begin
    if (rst || rollback) begin
      for (int i = 0; i < 64; i++) rf_tag[i] <= ENULL;
    end else if (rf_issue_sgn && rf_rd != RNULL) begin
      rf_tag[rf_rd] <= rf_rob_new_entry;
    end
  end

  always_comb begin
    rf_Qj = (rf_rs1 == RNULL) ? ENULL : rf_tag[rf_rs1];
    rf_Qk = (rf_rs2 == RNULL) ? ENULL : rf_tag[rf_rs2];
    rf_Vj = (rf_rs1 == RNULL || rf_Qj != ENULL) ? 32'd0 : arch_val(rf_rs1);
    rf_Vk = (rf_rs2 == RNULL || rf_Qk != ENULL) ? 32'd0 : arch_val(rf_rs2);
  end

  // Reference: program-order rename table plus issue/response queues.
  tag_t  m_tag [0:63];
  inst_t iss_q[$];
  inst_t resp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic s_in_ready, s_issue, s_acc, s_out_valid, s_out_slot, prev_issue;
  logic [5:0] s_rf_rd;
  tag_t s_rf_rob, s_out_Qj;
  logic [31:0] s_out_Vj;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic tag_t exp_q(input logic [5:0] r);
    return (r == RNULL) ? ENULL : m_tag[r];
  endfunction

  function automatic logic [31:0] exp_v(input logic [5:0] r);
    return (r == RNULL || m_tag[r] != ENULL) ? 32'd0 : arch_val(r);
  endfunction

  task automatic set_bundle(input logic [1:0] m,
                            input logic [5:0] d0, input logic [5:0] a0, input logic [5:0] b0, input tag_t r0,
                            input logic [5:0] d1, input logic [5:0] a1, input logic [5:0] b1, input tag_t r1);
    in_mask = m;
    in_rd0 = d0; in_rs1_0 = a0; in_rs2_0 = b0; in_rob0 = r0;
    in_rd1 = d1; in_rs1_1 = a1; in_rs2_1 = b1; in_rob1 = r1;
  endtask

  // Called just after a negedge; samples one unit before the next posedge.
  task automatic tick();
    inst_t e;
    #4;
    s_in_ready  = in_ready;   s_issue  = rf_issue_sgn;  s_acc    = in_valid && in_ready;
    s_rf_rd     = rf_rd;      s_rf_rob = rf_rob_new_entry;
    s_out_valid = out_valid;  s_out_slot = out_slot;    s_out_Qj = out_Qj;  s_out_Vj = out_Vj;

    if (!rdy || disp_stall) check("gated_issue", 32'(rf_issue_sgn), 32'd0);

    if (rf_issue_sgn) begin
      if (iss_q.size() == 0) check("unexpected_issue", 32'd1, 32'd0);
      else begin
        e = iss_q.pop_front();
        check("iss_rd",  32'(rf_rd),  32'(e.rd));
        check("iss_rs1", 32'(rf_rs1), 32'(e.rs1));
        check("iss_rs2", 32'(rf_rs2), 32'(e.rs2));
        check("iss_rob", 32'(rf_rob_new_entry), 32'(e.rob));
        resp_q.push_back(e);
      end
    end

    if (out_valid) begin
      if (resp_q.size() == 0) check("unexpected_resp", 32'd1, 32'd0);
      else begin
        e = resp_q.pop_front();
        check("resp_slot", 32'(out_slot), 32'(e.slot));
        check("resp_rob",  32'(out_rob),  32'(e.rob));
        check("resp_Qj",   32'(out_Qj),   32'(exp_q(e.rs1)));
        check("resp_Qk",   32'(out_Qk),   32'(exp_q(e.rs2)));
        check("resp_Vj",   out_Vj,        exp_v(e.rs1));
        check("resp_Vk",   out_Vk,        exp_v(e.rs2));
        if (e.rd != RNULL) m_tag[e.rd] = e.rob;
      end
    end

`ifdef ISSUE_SER_OUT_REG_EN
    check("resp_latency", 32'(out_valid), 32'(prev_issue));
`else
    check("resp_latency", 32'(out_valid), 32'(rf_issue_sgn));
    if (!out_valid)
      check("idle_out", {out_Vj | out_Vk}, 32'd0);
`endif
    prev_issue = rf_issue_sgn;

    if (rst) check("rst_in_ready", 32'(in_ready), 32'd0);

    if (rst || rollback) begin
      iss_q.delete();
      resp_q.delete();
      for (int i = 0; i < 64; i++) m_tag[i] = ENULL;
    end else if (in_valid && in_ready) begin
      if (in_mask[0]) iss_q.push_back('{1'b0, in_rob0, in_rd0, in_rs1_0, in_rs2_0});
      if (in_mask[1]) iss_q.push_back('{1'b1, in_rob1, in_rd1, in_rs1_1, in_rs2_1});
    end
    @(negedge clk);
  endtask

  function automatic logic [5:0] rnd_reg();
    int v = $urandom_range(0, 9);
    return (v >= 8) ? RNULL : 6'(v);
  endfunction

  function automatic tag_t rnd_rob();
    return tag_t'($urandom_range(1, 15));
  endfunction

  initial begin
    logic found;
    prev_issue = 1'b0;
    for (int i = 0; i < 64; i++) m_tag[i] = ENULL;

    @(negedge clk);
    tick();
    tick();
    check("rst_out_valid", 32'(s_out_valid), 32'd0);
    check("rst_out_slot",  32'(out_slot), 32'd0);
    check("rst_out_rob",   32'(out_rob),  32'(ENULL));
    check("rst_out_Qj",    32'(out_Qj),   32'(ENULL));
    check("rst_out_Qk",    32'(out_Qk),   32'(ENULL));
    check("rst_out_V",     out_Vj | out_Vk, 32'd0);
    rst = 1'b0;

    // Dependent pair: slot 1 reads slot 0's destination.
    set_bundle(2'b11, 6'd5, RNULL, RNULL, 4'd3, RNULL, 6'd5, RNULL, 4'd4);
    in_valid = 1'b1;
    tick();
    check("dep_accept", 32'(s_acc), 32'd1);
    in_valid = 1'b0;
    tick();
    check("dep_s0_issue", 32'(s_issue), 32'd1);
    check("dep_s0_rd",    32'(s_rf_rd), 32'd5);
    found = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (s_out_valid && s_out_slot && !found) begin
        found = 1'b1;
        check("dep_s1_Qj", 32'(s_out_Qj), 32'd3);
        check("dep_s1_Vj", s_out_Vj, 32'd0);
      end
    end
    check("dep_s1_seen", 32'(found), 32'd1);

    // Single-slot bundles back to back.
    set_bundle(2'b01, 6'd2, 6'd1, 6'd3, 4'd7, RNULL, RNULL, RNULL, 4'd8);
    in_valid = 1'b1;
    tick();
    check("single_accept", 32'(s_acc), 32'd1);
    set_bundle(2'b01, 6'd6, 6'd2, RNULL, 4'd9, RNULL, RNULL, RNULL, 4'd10);
    tick();
    check("single_issue", 32'(s_issue), 32'd1);
    check("single_rob",   32'(s_rf_rob), 32'd7);
    check("single_ready", 32'(s_in_ready), 32'd1);
    in_valid = 1'b0;
    tick();
    check("single_next_issue", 32'(s_issue), 32'd1);
    check("single_next_rob",   32'(s_rf_rob), 32'd9);
    tick();
    tick();

    // Empty mask is consumed and dropped.
    set_bundle(2'b00, 6'd1, 6'd1, 6'd1, 4'd1, 6'd1, 6'd1, 6'd1, 4'd2);
    in_valid = 1'b1;
    tick();
    check("m00_ready", 32'(s_in_ready), 32'd1);
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("m00_issue", 32'(s_issue), 32'd0);
      check("m00_out_valid", 32'(s_out_valid), 32'd0);
      check("m00_rf_rd", 32'(s_rf_rd), 32'(RNULL));
      check("m00_rf_rob", 32'(s_rf_rob), 32'(ENULL));
      check("m00_idle_ready", 32'(s_in_ready), 32'd1);
    end

    // disp_stall for two cycles in ISSUE0.
    set_bundle(2'b11, 6'd1, 6'd2, 6'd3, 4'd11, 6'd2, 6'd1, 6'd4, 4'd12);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    disp_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("stall_issue", 32'(s_issue), 32'd0);
      check("stall_ready", 32'(s_in_ready), 32'd0);
    end
    disp_stall = 1'b0;
    tick();
    check("stall_s0", 32'(s_issue), 32'd1);
    check("stall_s0_rob", 32'(s_rf_rob), 32'd11);
    tick();
    check("stall_s1", 32'(s_issue), 32'd1);
    check("stall_s1_rob", 32'(s_rf_rob), 32'd12);
    tick();
    check("stall_done", 32'(s_issue), 32'd0);
    tick();

    // Rollback in ISSUE0 of a full bundle.
    set_bundle(2'b11, 6'd7, 6'd6, RNULL, 4'd13, 6'd6, 6'd7, RNULL, 4'd14);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    rollback = 1'b1;
    tick();
    rollback = 1'b0;
    tick();
    check("rb_issue", 32'(s_issue), 32'd0);
    check("rb_out_valid", 32'(s_out_valid), 32'd0);
    check("rb_idle_ready", 32'(s_in_ready), 32'd1);
    tick();
    check("rb_no_s1", 32'(s_issue), 32'd0);

    // rdy low for three cycles between slot 0 and slot 1.
    set_bundle(2'b11, 6'd3, 6'd4, 6'd5, 4'd5, 6'd4, 6'd3, RNULL, 4'd6);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("rdy_s0", 32'(s_issue), 32'd1);
    check("rdy_s0_rob", 32'(s_rf_rob), 32'd5);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rdy_hold_issue", 32'(s_issue), 32'd0);
      check("rdy_hold_ready", 32'(s_in_ready), 32'd0);
    end
    rdy = 1'b1;
    tick();
    check("rdy_resume", 32'(s_issue), 32'd1);
    check("rdy_resume_rob", 32'(s_rf_rob), 32'd6);
    tick();
    tick();

    // Random traffic; a bundle is held until it is accepted.
    s_acc = 1'b1;
    for (int n = 0; n < 600; n++) begin
      if (!in_valid || s_acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        set_bundle(2'($urandom_range(0, 3)),
                   rnd_reg(), rnd_reg(), rnd_reg(), rnd_rob(),
                   rnd_reg(), rnd_reg(), rnd_reg(), rnd_rob());
      end
      disp_stall = ($urandom_range(0, 6) == 0);
      rdy        = ($urandom_range(0, 9) != 0);
      rollback   = ($urandom_range(0, 29) == 0);
      tick();
    end

    in_valid = 1'b0; disp_stall = 1'b0; rdy = 1'b1; rollback = 1'b0;
    for (int n = 0; n < 20 && (iss_q.size() != 0 || resp_q.size() != 0); n++) tick();
    tick();
    check("drain_issue_queue", 32'(iss_q.size()), 32'd0);
    check("drain_resp_queue", 32'(resp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
